// File: rtl/ika2151_regwr_sched.sv
// rtl/ika2151_regwr_sched.sv - CPU register write scheduler aligned to the 32-slot frame
//
// Purpose: captures asynchronous CPU address/data writes, then replays each
// accepted data write to the register file for one full 32-slot frame.
//
// Ports:
//   i_EMUCLK       master clock, all flops on posedge
//   i_IC_n         asynchronous active-low reset
//   i_phi1_NCEN_n  phi1 clock enable (active-low); FSM and outputs advance only here
//   i_CYCLE_01     frame marker, one phi1 cycle in 32
//   i_CS_n/i_WR_n  CPU chip select / write strobe (async, active-low)
//   i_A0, i_D      CPU register select (0 addr, 1 data) and write data
//   o_BUSY         data write in progress
//   o_ADDR/o_DATA  current register address / write data
//   o_ADDR_WR_STB  one phi1 cycle pulse when o_ADDR is loaded
//   o_WR_FRAME     high for the 32 phi1 cycles of the write frame
//   o_WR_SLOT      slot index during the frame, 0 otherwise
//   o_WR_DROP      one phi1 cycle pulse when a data write is rejected

module ika2151_regwr_sched #(
    parameter int BUSY_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_EMUCLK,
    input  logic       i_IC_n,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CYCLE_01,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    output logic       o_BUSY,
    output logic [7:0] o_ADDR,
    output logic [7:0] o_DATA,
    output logic       o_ADDR_WR_STB,
    output logic       o_WR_FRAME,
    output logic [4:0] o_WR_SLOT,
    output logic       o_WR_DROP
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_FRAME = 2'd2,
        S_TAIL  = 2'd3
    } state_t;

    logic ncen;
    assign ncen = ~i_phi1_NCEN_n;

    // ------------------------------------------------------------------
    // CPU capture, free-running on EMUCLK
    // ------------------------------------------------------------------
    logic                   wr_act;
    logic                   wr_sync;
    logic                   commit;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   wr_prev_q;
    logic                   hold_a0_q;
    logic [7:0]             hold_d_q;

    assign wr_act  = ~i_CS_n & ~i_WR_n;
    // Requiring every stage high rejects strobes shorter than SYNC_STAGES clocks.
    assign wr_sync = &sync_q;
    assign commit  = wr_prev_q & ~wr_sync;

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            sync_q    <= '0;
            wr_prev_q <= 1'b0;
            hold_a0_q <= 1'b0;
            hold_d_q  <= 8'd0;
        end else begin
            if (wr_act) begin
                hold_a0_q <= i_A0;
                hold_d_q  <= i_D;
            end
            sync_q    <= {sync_q[SYNC_STAGES-2:0], wr_act};
            wr_prev_q <= wr_sync;
        end
    end

    // ------------------------------------------------------------------
    // Pending flags: set on commit, consumed by the FSM at NCEN.
    // Each kind keeps its own value so a later write of the other kind
    // cannot corrupt it through the shared holding register.
    // ------------------------------------------------------------------
    logic       pend_addr_q;
    logic       pend_data_q;
    logic [7:0] pend_addr_val_q;
    logic [7:0] pend_data_val_q;
    logic       take_addr;
    logic       take_data;

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            pend_addr_q     <= 1'b0;
            pend_data_q     <= 1'b0;
            pend_addr_val_q <= 8'd0;
            pend_data_val_q <= 8'd0;
        end else begin
            // A fresh commit wins over a consume in the same clock.
            if (commit && !hold_a0_q) begin
                pend_addr_q     <= 1'b1;
                pend_addr_val_q <= hold_d_q;
            end else if (take_addr) begin
                pend_addr_q <= 1'b0;
            end
            if (commit && hold_a0_q) begin
                pend_data_q     <= 1'b1;
                pend_data_val_q <= hold_d_q;
            end else if (take_data) begin
                pend_data_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] busy_cnt_q, busy_cnt_d;
    logic [7:0] busy_dec;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       stb_q, stb_d;
    logic       frame_q, frame_d;
    logic [4:0] slot_q, slot_d;
    logic       drop_q, drop_d;

    // Saturating decrement; decisions use the post-decrement value so BUSY
    // lasts exactly BUSY_CYCLES phi1 cycles when the frame ends earlier.
    assign busy_dec = (busy_cnt_q != 8'd0) ? busy_cnt_q - 8'd1 : 8'd0;

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ncen) begin
            case (state_q)
                S_IDLE:  if (!pend_addr_q && pend_data_q) state_d = S_ALIGN;
                S_ALIGN: if (i_CYCLE_01) state_d = S_FRAME;
                S_FRAME: if (slot_q == 5'd31) state_d = (busy_dec != 8'd0) ? S_TAIL : S_IDLE;
                S_TAIL:  if (busy_dec == 8'd0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        stb_d      = stb_q;
        frame_d    = frame_q;
        slot_d     = slot_q;
        drop_d     = drop_q;
        busy_cnt_d = busy_cnt_q;
        take_addr  = 1'b0;
        take_data  = 1'b0;
        if (ncen) begin
            stb_d  = 1'b0;
            drop_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Address first; a data write pending alongside waits one NCEN.
                    if (pend_addr_q) begin
                        addr_d    = pend_addr_val_q;
                        stb_d     = 1'b1;
                        take_addr = 1'b1;
                    end else if (pend_data_q) begin
                        data_d     = pend_data_val_q;
                        busy_cnt_d = 8'(BUSY_CYCLES);
                        take_data  = 1'b1;
                    end
                end
                S_ALIGN: begin
                    busy_cnt_d = busy_dec;
                    if (i_CYCLE_01) begin
                        frame_d = 1'b1;
                        slot_d  = 5'd0;
                    end
                end
                S_FRAME: begin
                    busy_cnt_d = busy_dec;
                    if (slot_q == 5'd31) begin
                        frame_d = 1'b0;
                        slot_d  = 5'd0;
                    end else begin
                        slot_d = slot_q + 5'd1;
                    end
                end
                S_TAIL: busy_cnt_d = busy_dec;
                default: busy_cnt_d = busy_cnt_q;
            endcase
            // Data writes arriving while busy are discarded, leaving o_DATA intact.
            if (state_q != S_IDLE && pend_data_q) begin
                drop_d    = 1'b1;
                take_data = 1'b1;
            end
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            addr_q     <= 8'd0;
            data_q     <= 8'd0;
            stb_q      <= 1'b0;
            frame_q    <= 1'b0;
            slot_q     <= 5'd0;
            drop_q     <= 1'b0;
            busy_cnt_q <= 8'd0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            stb_q      <= stb_d;
            frame_q    <= frame_d;
            slot_q     <= slot_d;
            drop_q     <= drop_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign o_BUSY        = (state_q != S_IDLE);
    assign o_ADDR        = addr_q;
    assign o_DATA        = data_q;
    assign o_ADDR_WR_STB = stb_q;
    assign o_WR_FRAME    = frame_q;
    assign o_WR_SLOT     = slot_q;
    assign o_WR_DROP     = drop_q;

endmodule

// File: tb/tb_ika2151_regwr_sched.sv
// tb/tb_ika2151_regwr_sched.sv - self-checking bench for ika2151_regwr_sched

module tb_ika2151_regwr_sched;

    localparam int B = 64;

    logic       clk = 1'b0;
    logic       rst_n, ncen_n, cyc01, cs_n, cs8_n, wr_n, a0;
    logic [7:0] d;

    logic       o_busy, o_stb, o_frame, o_drop;
    logic [7:0] o_addr, o_data;
    logic [4:0] o_slot;
    logic       b8_busy, b8_stb, b8_frame, b8_drop;
    logic [7:0] b8_addr, b8_data;
    logic [4:0] b8_slot;

    always #5 clk = ~clk;

    ika2151_regwr_sched dut (
        .i_EMUCLK(clk), .i_IC_n(rst_n), .i_phi1_NCEN_n(ncen_n), .i_CYCLE_01(cyc01),
        .i_CS_n(cs_n), .i_WR_n(wr_n), .i_A0(a0), .i_D(d),
        .o_BUSY(o_busy), .o_ADDR(o_addr), .o_DATA(o_data), .o_ADDR_WR_STB(o_stb),
        .o_WR_FRAME(o_frame), .o_WR_SLOT(o_slot), .o_WR_DROP(o_drop)
    );

    ika2151_regwr_sched #(.BUSY_CYCLES(8)) dut8 (
        .i_EMUCLK(clk), .i_IC_n(rst_n), .i_phi1_NCEN_n(ncen_n), .i_CYCLE_01(cyc01),
        .i_CS_n(cs8_n), .i_WR_n(wr_n), .i_A0(a0), .i_D(d),
        .o_BUSY(b8_busy), .o_ADDR(b8_addr), .o_DATA(b8_data), .o_ADDR_WR_STB(b8_stb),
        .o_WR_FRAME(b8_frame), .o_WR_SLOT(b8_slot), .o_WR_DROP(b8_drop)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a data job is described by its accept index t0 and
    // frame start f; everything else follows from arithmetic on NCEN index n.
    int         n = 0;
    logic       m_job, m_pa, m_pd, m_stb, m_drop, m_frame;
    logic [7:0] m_pav, m_pdv, m_addr, m_data;
    int         m_t0, m_f, m_slot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_job = 0; m_pa = 0; m_pd = 0; m_stb = 0; m_drop = 0; m_frame = 0;
        m_pav = 0; m_pdv = 0; m_addr = 0; m_data = 0;
        m_t0 = 0; m_f = -1; m_slot = 0;
    endtask

    task automatic model_ncen(input int kind, input logic a0v, input logic [7:0] dv, input logic marker);
        int e;
        if (kind == 1) begin
            if (a0v) begin m_pd = 1; m_pdv = dv; end
            else     begin m_pa = 1; m_pav = dv; end
        end
        m_stb = 0;
        m_drop = 0;
        if (!m_job) begin
            if (m_pa) begin
                m_addr = m_pav; m_stb = 1; m_pa = 0;
            end else if (m_pd) begin
                m_data = m_pdv; m_job = 1; m_t0 = n; m_f = -1; m_pd = 0;
            end
        end else begin
            if (m_f < 0 && marker) m_f = n;
            if (m_f >= 0) begin
                e = m_t0 + B;
                if (m_f + 32 > e) e = m_f + 32;
                if (n >= e) m_job = 0;
            end
            if (m_pd) begin m_drop = 1; m_pd = 0; end
        end
        m_frame = (m_f >= 0) && (n >= m_f) && (n < m_f + 32);
        m_slot  = m_frame ? n - m_f : 0;
        n++;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".busy"},  32'(o_busy),  32'(m_job));
        chk({where, ".addr"},  32'(o_addr),  32'(m_addr));
        chk({where, ".data"},  32'(o_data),  32'(m_data));
        chk({where, ".stb"},   32'(o_stb),   32'(m_stb));
        chk({where, ".frame"}, 32'(o_frame), 32'(m_frame));
        chk({where, ".slot"},  32'(o_slot),  32'(m_slot));
        chk({where, ".drop"},  32'(o_drop),  32'(m_drop));
    endtask

    // One phi1 cycle = 16 EMUCLKs; an optional CPU access occupies the first
    // four, and the NCEN clock is the last. kind: 0 none, 1 write, 2 short
    // strobe, 3 write with CS_n high, 4 write to the BUSY_CYCLES=8 instance.
    task automatic phi(input int kind, input logic a0v, input logic [7:0] dv, input logic marker);
        ncen_n = 1; cyc01 = 0;
        a0 = a0v; d = dv;
        case (kind)
            1: begin cs_n = 0; wr_n = 0; repeat (4) @(negedge clk); cs_n = 1; wr_n = 1; end
            2: begin cs_n = 0; wr_n = 0; @(negedge clk); wr_n = 1; repeat (3) @(negedge clk); cs_n = 1; end
            3: begin cs_n = 1; wr_n = 0; repeat (4) @(negedge clk); wr_n = 1; end
            4: begin cs8_n = 0; wr_n = 0; repeat (4) @(negedge clk); cs8_n = 1; wr_n = 1; end
            default: repeat (4) @(negedge clk);
        endcase
        repeat (11) @(negedge clk);
        ncen_n = 0; cyc01 = marker;
        @(negedge clk);
        ncen_n = 1; cyc01 = 0;
        model_ncen(kind, a0v, dv, marker);
        check_outputs($sformatf("n%0d", n - 1));
    endtask

    initial begin
        int cnt_stb, cnt_busy, cnt_frame, cnt_drop, bad_addr, last_slot;
        logic found;
        rst_n = 0; ncen_n = 1; cyc01 = 0; cs_n = 1; cs8_n = 1; wr_n = 1; a0 = 0; d = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        chk("reset.b8_busy", 32'(b8_busy), 32'd0);
        chk("reset.b8_regs", 32'({b8_addr, b8_data, b8_slot}), 32'd0);
        chk("reset.b8_pulses", 32'({b8_stb, b8_frame, b8_drop}), 32'd0);
        rst_n = 1;
        @(negedge clk);

        // Idle for 100 phi1 cycles.
        for (int i = 0; i < 100; i++) phi(0, 0, 8'h00, (i % 32) == 5);

        // Address 0x28 then data 0x5A, marker 10 cycles after accept.
        cnt_stb = 0; cnt_busy = 0; cnt_frame = 0;
        phi(1, 0, 8'h28, 0); cnt_stb += int'(o_stb);
        phi(1, 1, 8'h5A, 0); cnt_stb += int'(o_stb); cnt_busy += int'(o_busy);
        for (int i = 1; i < 80; i++) begin
            phi(0, 0, 8'h00, i == 10);
            cnt_stb += int'(o_stb); cnt_busy += int'(o_busy); cnt_frame += int'(o_frame);
        end
        chk("t2.stb_count", 32'(cnt_stb), 32'd1);
        chk("t2.busy_len", 32'(cnt_busy), 32'd64);
        chk("t2.frame_len", 32'(cnt_frame), 32'd32);
        chk("t2.addr", 32'(o_addr), 32'h28);

        // BUSY_CYCLES = 8 instance, marker 20 cycles after accept.
        cnt_busy = 0; cnt_frame = 0; last_slot = -1;
        phi(4, 1, 8'h77, 0); cnt_busy += int'(b8_busy);
        for (int i = 1; i < 80; i++) begin
            phi(0, 0, 8'h00, i == 20);
            if (b8_busy) begin cnt_busy++; last_slot = int'(b8_slot); end
            cnt_frame += int'(b8_frame);
        end
        chk("t3.busy_len", 32'(cnt_busy), 32'd52);
        chk("t3.last_busy_slot", 32'(last_slot), 32'd31);
        chk("t3.frame_len", 32'(cnt_frame), 32'd32);
        chk("t3.data", 32'(b8_data), 32'h77);

        // Drop during frame, address held until idle.
        cnt_drop = 0; cnt_stb = 0; bad_addr = 0;
        phi(1, 1, 8'h11, 0);
        for (int i = 1; i < 80; i++) begin
            phi((i == 10 || i == 12) ? 1 : 0, i == 10, (i == 10) ? 8'h22 : 8'h30, i == 4);
            cnt_drop += int'(o_drop); cnt_stb += int'(o_stb);
            if (o_busy && o_addr != 8'h28) bad_addr++;
        end
        chk("t4.drop_count", 32'(cnt_drop), 32'd1);
        chk("t4.stb_count", 32'(cnt_stb), 32'd1);
        chk("t4.addr_changed_busy", 32'(bad_addr), 32'd0);
        chk("t4.addr_final", 32'(o_addr), 32'h30);
        chk("t4.data_final", 32'(o_data), 32'h11);

        // Reset at slot 15, then a fresh full frame.
        found = 0;
        phi(1, 1, 8'h44, 0);
        for (int i = 1; i < 40 && !found; i++) begin
            phi(0, 0, 8'h00, i == 3);
            if (o_slot == 5'd15) found = 1;
        end
        chk("t5.slot15_reached", 32'(found), 32'd1);
        rst_n = 0;
        #1;
        model_reset();
        check_outputs("t5.reset");
        repeat (4) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        cnt_frame = 0;
        phi(1, 1, 8'h99, 0);
        for (int i = 1; i < 70; i++) begin
            phi(0, 0, 8'h00, i == 7);
            cnt_frame += int'(o_frame);
        end
        chk("t5.frame_len", 32'(cnt_frame), 32'd32);

        // Short strobes and CS_n-high writes never commit.
        for (int i = 0; i < 6; i++) phi((i % 2 == 0) ? 2 : 3, i < 3, 8'h55 + 8'(i), 0);
        for (int i = 0; i < 10; i++) phi(0, 0, 8'h00, i == 2);
        chk("t6.busy", 32'(o_busy), 32'd0);
        chk("t6.data", 32'(o_data), 32'h99);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            phi((r == 0 || r == 1 || r == 2) ? 1 : (r == 3) ? 2 : (r == 4) ? 3 : 0,
                r != 0, 8'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
